// File: rtl/sram_access_pkg.sv
// rtl/sram_access_pkg.sv - shared types, idle control levels and byte-enable helper for the SRAM arbiter
package sram_access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD
    } state_t;

    localparam logic        CE_N_OFF     = 1'b1;
    localparam logic        OE_N_OFF     = 1'b1;
    localparam logic        WE_N_OFF     = 1'b1;
    localparam logic [31:0] BE_N_ALL_OFF = '1;

    // Wide enough for any supported data width; callers cast down to their lane count.
    function automatic logic [31:0] be_to_be_n(input logic [31:0] be);
        return ~be;
    endfunction

endpackage

// File: rtl/sram_arb_2to1.sv
// rtl/sram_arb_2to1.sv - read-priority grant with saturating write-starvation counter
module sram_arb_2to1 #(
    parameter int WR_MAX_WAIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic idle,
    input  logic rd_req,
    input  logic wr_req,
    output logic grant_rd,
    output logic grant_wr
);

    localparam int WW = $clog2(WR_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(WR_MAX_WAIT);

    logic [WW-1:0] wait_cnt;
    logic          force_wr;

    assign force_wr = (wait_cnt >= WAIT_MAX);
    assign grant_wr = idle && wr_req && (!rd_req || force_wr);
    assign grant_rd = idle && rd_req && !grant_wr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (grant_wr) begin
            wait_cnt <= '0;
        end else if (grant_rd && wr_req && (wait_cnt < WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - shares async SRAM pins between a real-time read port and a write port
module sram_access_arbiter
    import sram_access_pkg::*;
#(
    parameter int SRAM_AW     = 18,
    parameter int SRAM_DW     = 16,
    parameter int RD_CYCLES   = 2,
    parameter int WR_CYCLES   = 1,
    parameter int WR_MAX_WAIT = 4
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   rd_req,
    input  logic [SRAM_AW-1:0]     rd_addr,
    output logic                   rd_ready,
    output logic                   rd_rvalid,
    output logic [SRAM_DW-1:0]     rd_rdata,
    input  logic                   wr_req,
    input  logic [SRAM_AW-1:0]     wr_addr,
    input  logic [SRAM_DW-1:0]     wr_wdata,
    input  logic [SRAM_DW/8-1:0]   wr_be,
    output logic                   wr_ready,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic [SRAM_DW/8-1:0]   sram_be_n,
    output logic [SRAM_AW-1:0]     sram_addr,
    inout  wire  [SRAM_DW-1:0]     sram_dq
);

    localparam int BE_W    = SRAM_DW / 8;
    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0]   RD_LAST  = CW'(RD_CYCLES - 1);
    localparam logic [CW-1:0]   WR_LAST  = CW'(WR_CYCLES - 1);
    localparam logic [BE_W-1:0] BE_N_OFF = BE_W'(BE_N_ALL_OFF);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [SRAM_DW-1:0]  wdata_q;
    logic [BE_W-1:0]     be_q;
    logic                dq_oe;
    logic                grant_rd;
    logic                grant_wr;

    // Ready is suppressed during reset so nothing is accepted on a reset edge.
    sram_arb_2to1 #(
        .WR_MAX_WAIT (WR_MAX_WAIT)
    ) u_arb (
        .clk      (sys_clk),
        .resetn   (sys_rst_n),
        .idle     ((state == ST_IDLE) && sys_rst_n),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .grant_rd (grant_rd),
        .grant_wr (grant_wr)
    );

    assign rd_ready = grant_rd;
    assign wr_ready = grant_wr;
    assign sram_dq  = dq_oe ? wdata_q : {SRAM_DW{1'bz}};

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            dq_oe     <= 1'b0;
            rd_rvalid <= 1'b0;
            rd_rdata  <= '0;
            sram_ce_n <= CE_N_OFF;
            sram_oe_n <= OE_N_OFF;
            sram_we_n <= WE_N_OFF;
            sram_be_n <= BE_N_OFF;
            sram_addr <= '0;
        end else begin
            rd_rvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (grant_rd) begin
                        state     <= ST_RD;
                        sram_addr <= rd_addr;
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                        sram_be_n <= '0;
                    end else if (grant_wr) begin
                        state     <= ST_WR_SETUP;
                        sram_addr <= wr_addr;
                        wdata_q   <= wr_wdata;
                        be_q      <= wr_be;
                        dq_oe     <= 1'b1;
                    end
                end
                ST_RD: begin
                    if (cnt == RD_LAST) begin
                        state     <= ST_IDLE;
                        rd_rdata  <= sram_dq;
                        rd_rvalid <= 1'b1;
                        sram_ce_n <= CE_N_OFF;
                        sram_oe_n <= OE_N_OFF;
                        sram_be_n <= BE_N_OFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WR_SETUP: begin
                    state     <= ST_WR_PULSE;
                    cnt       <= '0;
                    sram_ce_n <= 1'b0;
                    sram_we_n <= 1'b0;
                    sram_be_n <= BE_W'(be_to_be_n(32'(be_q)));
                end
                ST_WR_PULSE: begin
                    if (cnt == WR_LAST) begin
                        state     <= ST_WR_HOLD;
                        sram_ce_n <= CE_N_OFF;
                        sram_we_n <= WE_N_OFF;
                        sram_be_n <= BE_N_OFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WR_HOLD: begin
                    state <= ST_IDLE;
                    dq_oe <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    dq_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - directed-vector bench with a behavioural async SRAM on the pins
module tb_sram_access_arbiter;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        rd_req;
    logic [17:0] rd_addr;
    logic        rd_ready;
    logic        rd_rvalid;
    logic [15:0] rd_rdata;
    logic        wr_req;
    logic [17:0] wr_addr;
    logic [15:0] wr_wdata;
    logic [1:0]  wr_be;
    logic        wr_ready;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [1:0]  sram_be_n;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] mem [0:255];
    int          we_low_cnt  = 0;
    int          rvalid_cnt  = 0;
    int          overlap_cnt = 0;
    logic [1:0]  last_be_n   = 2'b11;

    sram_access_arbiter dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .rd_rvalid (rd_rvalid),
        .rd_rdata  (rd_rdata),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_wdata  (wr_wdata),
        .wr_be     (wr_be),
        .wr_ready  (wr_ready),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_be_n (sram_be_n),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Async SRAM: drives dq while selected and output-enabled, writes enabled bytes during the we_n pulse.
    assign sram_dq = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

    always @(posedge sys_clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_be_n[0]) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
            if (!sram_be_n[1]) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
        end
    end

    always @(negedge sys_clk) begin
        if (!sram_we_n) begin
            we_low_cnt = we_low_cnt + 1;
            last_be_n  = sram_be_n;
        end
        if (rd_rvalid) rvalid_cnt = rvalid_cnt + 1;
        if (!sram_oe_n && !sram_we_n) overlap_cnt = overlap_cnt + 1;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
        int n;
        @(negedge sys_clk);
        wr_req = 1'b1; wr_addr = a; wr_wdata = d; wr_be = be;
        n = 0;
        #1;
        while (!wr_ready && n < 50) begin
            @(negedge sys_clk); #1; n++;
        end
        check_vec("wr_accept", 32'(n < 50), 32'd1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        wr_req = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic do_read(input logic [17:0] a, output logic [15:0] d, output int lat);
        int n;
        @(negedge sys_clk);
        rd_req = 1'b1; rd_addr = a;
        n = 0;
        #1;
        while (!rd_ready && n < 50) begin
            @(negedge sys_clk); #1; n++;
        end
        check_vec("rd_accept", 32'(n < 50), 32'd1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        rd_req = 1'b0;
        lat = 1;
        while (!rd_rvalid && lat < 20) begin
            @(negedge sys_clk); lat++;
        end
        d = rd_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int          lat, base, n, acc, got, cyc, last, idx, reads, rounds;

        sys_rst_n = 1'b0;
        rd_req = 1'b1; rd_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_wdata = '0; wr_be = '0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_vec("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check_vec("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check_vec("rst_we_n", 32'(sram_we_n), 32'd1);
        check_vec("rst_be_n", 32'(sram_be_n), 32'h3);
        check_vec("rst_addr", 32'(sram_addr), 32'h0);
        check_vec("rst_rd_ready", 32'(rd_ready), 32'd0);
        check_vec("rst_wr_ready", 32'(wr_ready), 32'd0);
        check_vec("rst_rvalid", 32'(rd_rvalid), 32'd0);
        rd_req = 1'b0;
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Write then read back
        base = we_low_cnt;
        do_write(18'h00010, 16'hA5A5, 2'b11);
        check_vec("wr_we_low_cycles", 32'(we_low_cnt - base), 32'd1);
        do_read(18'h00010, d, lat);
        check_vec("rd_latency", 32'(lat), 32'd3);
        check_vec("rd_data_a5a5", 32'(d), 32'hA5A5);

        // Byte enables
        do_write(18'h00020, 16'h1234, 2'b11);
        do_write(18'h00020, 16'hAB00, 2'b10);
        check_vec("be10_be_n", 32'(last_be_n), 32'h1);
        do_read(18'h00020, d, lat);
        check_vec("be_merge", 32'(d), 32'hAB34);
        base = we_low_cnt;
        do_write(18'h00020, 16'hFFFF, 2'b00);
        check_vec("be00_we_pulse", 32'(we_low_cnt - base), 32'd1);
        check_vec("be00_be_n", 32'(last_be_n), 32'h3);
        do_read(18'h00020, d, lat);
        check_vec("be00_unchanged", 32'(d), 32'hAB34);

        // Starvation guard, two rounds so the second proves the counter cleared
        @(negedge sys_clk);
        rd_req = 1'b1; rd_addr = 18'h00010;
        wr_req = 1'b1; wr_addr = 18'h00030; wr_wdata = 16'h5A5A; wr_be = 2'b11;
        rounds = 0; reads = 0; cyc = 0;
        while (rounds < 2 && cyc < 200) begin
            #1;
            if (rd_ready) reads++;
            if (wr_ready) begin
                check_vec($sformatf("starve_reads_r%0d", rounds), 32'(reads), 32'd4);
                reads = 0;
                rounds++;
            end
            @(negedge sys_clk);
            cyc++;
        end
        check_vec("starve_rounds", 32'(rounds), 32'd2);
        rd_req = 1'b0; wr_req = 1'b0;
        repeat (8) @(negedge sys_clk);
        do_read(18'h00030, d, lat);
        check_vec("starve_wr_data", 32'(d), 32'h5A5A);

        // Streaming reads
        for (int i = 0; i < 8; i++) do_write(18'(i), 16'h1000 + 16'(i), 2'b11);
        @(negedge sys_clk);
        rd_req = 1'b1; rd_addr = '0;
        idx = 0; got = 0; cyc = 0; last = 0;
        while (got < 8 && cyc < 100) begin
            #1;
            acc = int'(rd_ready && rd_req);
            @(negedge sys_clk);
            cyc++;
            if (rd_rvalid) begin
                check_vec($sformatf("stream_data_%0d", got), 32'(rd_rdata), 32'h1000 + 32'(got));
                if (got > 0) check_vec($sformatf("stream_gap_%0d", got), 32'(cyc - last), 32'd3);
                last = cyc;
                got++;
            end
            if (acc != 0) begin
                idx++;
                if (idx < 8) rd_addr = 18'(idx);
                else rd_req = 1'b0;
            end
        end
        check_vec("stream_count", 32'(got), 32'd8);
        rd_req = 1'b0;
        repeat (3) @(negedge sys_clk);

        // Reset in the middle of a read
        @(negedge sys_clk);
        rd_req = 1'b1; rd_addr = 18'h00010;
        n = 0;
        #1;
        while (!rd_ready && n < 50) begin
            @(negedge sys_clk); #1; n++;
        end
        check_vec("midrst_accept", 32'(n < 50), 32'd1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        rd_req = 1'b0;
        base = rvalid_cnt;
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check_vec("midrst_ce_n", 32'(sram_ce_n), 32'd1);
        check_vec("midrst_oe_n", 32'(sram_oe_n), 32'd1);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        check_vec("midrst_no_rvalid", 32'(rvalid_cnt - base), 32'd0);
        do_read(18'h00010, d, lat);
        check_vec("midrst_after_lat", 32'(lat), 32'd3);
        check_vec("midrst_after_data", 32'(d), 32'hA5A5);

        check_vec("oe_we_overlap", 32'(overlap_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Single-clock controller that owns the external asynchronous SRAM pins (ce_n/oe_n/we_n/be_n/addr/dq) and shares them between two requesters: a read port (framebuffer pixel fetch, real-time) and a write port (system/Avalon pixel writes).
- Sequences fixed-timing SRAM read and write cycles.
- Arbitrates with read priority and a write-starvation guard.
- Sits between the video framebuffer logic and the SRAM pins in the sys_clk domain.

Parameters:
- SRAM_AW, 18, SRAM address width.
- SRAM_DW, 16, SRAM data width (multiple of 8).
- RD_CYCLES, 2, cycles ce_n/oe_n held low per read (>=1).
- WR_CYCLES, 1, cycles we_n held low per write (>=1).
- WR_MAX_WAIT, 4, lost arbitrations after which a pending write is forced to win (>=1).

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  synchronous reset, active low
- rd_req  in  1  read request, held until rd_ready
- rd_addr  in  SRAM_AW  read word address
- rd_ready  out  1  read accepted this cycle
- rd_rvalid  out  1  one-cycle pulse, rd_rdata valid
- rd_rdata  out  SRAM_DW  read data
- wr_req  in  1  write request, held until wr_ready
- wr_addr  in  SRAM_AW  write word address
- wr_wdata  in  SRAM_DW  write data
- wr_be  in  SRAM_DW/8  byte enables, active high
- wr_ready  out  1  write accepted this cycle
- sram_ce_n  out  1  chip enable
- sram_oe_n  out  1  output enable
- sram_we_n  out  1  write enable
- sram_be_n  out  SRAM_DW/8  byte enables, active low
- sram_addr  out  SRAM_AW  address
- sram_dq  inout  SRAM_DW  data bus

Behaviour:
- Reset (sys_rst_n=0 at an edge): state IDLE; ce_n=oe_n=we_n=1; be_n all 1; sram_addr=0; dq released (Z); rd_ready=wr_ready=rd_rvalid=0; rd_rdata=0; starvation counter=0. All SRAM control outputs are registered.
- Transfer handshake: a transfer occurs on a cycle where req&&ready. ready is combinational, high only in IDLE for the granted port. The requester holds addr/data/be stable until ready. The controller latches them on the accept edge.
- Arbitration (IDLE only):
  - Only one req: that port wins.
  - Both req: read wins unless wait_cnt>=WR_MAX_WAIT, then write wins.
  - wait_cnt increments (saturating at WR_MAX_WAIT) on each accept edge where read wins while wr_req=1. It clears when a write is accepted.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- Read, accept at cycle T:
  - RD for cycles T+1..T+RD_CYCLES: ce_n=0, oe_n=0, we_n=1, be_n all 0, addr=latched.
  - sram_dq is sampled at the end of the last RD cycle.
  - rd_rvalid=1 during T+RD_CYCLES+1; state returns to IDLE in that same cycle, so a new request can be accepted.
  - Back-to-back read throughput: one per RD_CYCLES+1 cycles.
- Write, accept at cycle T:
  - WR_SETUP, 1 cycle: ce_n=1, we_n=1, addr and dq driven.
  - WR_PULSE, WR_CYCLES cycles: ce_n=0, we_n=0, oe_n=1, be_n=~wr_be.
  - WR_HOLD, 1 cycle: ce_n=1, we_n=1, dq still driven.
  - Then IDLE. ce_n stays high outside the pulse so the SRAM never drives dq while the controller does.
- dq drive enable: high only in WR_SETUP/WR_PULSE/WR_HOLD. Never high in the same cycle as oe_n=0.
- wr_be=0: accepted and sequenced normally; be_n all 1, so memory is unchanged.
- sram_addr holds its last value in IDLE. No address wrap or arithmetic.
- Reset mid-transaction: the in-flight access is dropped and no rd_rvalid is issued. Controls go inactive at the reset edge.

Decomposition:
- Shared package sram_access_pkg:
  - state enum
  - idle control constants (CE/OE/WE inactive, BE_N all ones)
  - function computing wr_be to be_n.
- Sub-module sram_arb_2to1: combinational grant plus the registered saturating wait_cnt; outputs grant_rd/grant_wr.

Test Plan:
- Reset: hold sys_rst_n=0 three cycles with rd_req=1 -> ce_n/oe_n/we_n=1, be_n=2'b11, dq=Z, no ready/rvalid.
- Write then read (RD_CYCLES=2): write addr 0x00010 data 0xA5A5 be 2'b11, then read 0x00010 -> we_n low exactly 1 cycle; rd_rvalid 3 cycles after read accept; rd_rdata=0xA5A5.
- Byte enable: write 0x1234 at 0x20 be 2'b11, then 0xAB00 at 0x20 be 2'b10 -> read returns 0xAB34. wr_be=0 write of 0xFFFF -> read still 0xAB34.
- Starvation: rd_req held high continuously plus one wr_req -> exactly 4 reads accepted, then the write; wait_cnt returns to 0.
- Streaming: 8 back-to-back reads of addresses 0..7 preloaded with 0x1000+addr -> rd_rvalid every 3 cycles, data in order.
- Reset mid-read: assert reset during RD -> no rd_rvalid; ce_n=1 after that edge; a subsequent read of a known address completes normally.
